// File: rtl/uart_receptor_pkg.sv
// Shared definitions for the UART receiver (and the matching transmitter).
// - NBIT_DATA_LEN     : default number of data bits per frame
// - NUM_TICKS_DEFAULT : default oversampling ticks per bit
// - IDLE..BREAK       : 3-bit state encodings shared by the UART FSMs
package uart_receptor_pkg;

    localparam int unsigned NBIT_DATA_LEN     = 8;
    localparam int unsigned NUM_TICKS_DEFAULT = 16;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = IDLE,
        StStart = START,
        StData  = DATA,
        StStop  = STOP,
        StBreak = BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_receptor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// - clk   : destination clock
// - reset : asynchronous active-low reset, loads RESET_VALUE into both flops
// - d     : asynchronous input
// - q     : synchronized output, two clk cycles of latency
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VALUE;
            q      <= RESET_VALUE;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_receptor.sv
// UART receiver: 1 start bit, NBIT_DATA data bits LSB first, 1 stop bit, no parity.
// The line is sampled in the middle of each bit using a 16x (NUM_TICKS) oversampling tick.
// - clk          : system clock
// - reset        : asynchronous active-low reset
// - tick         : one-clk oversampling enable from the baud-rate generator
// - rx_bit       : asynchronous serial line, idles high
// - data_out     : last received word, held until the next frame completes
// - rx_done_tick : one-clk pulse when a frame completes
// - frame_err    : stop-bit status of the last frame (1 = stop bit was low)
module uart_receptor
    import uart_receptor_pkg::*;
#(
    parameter int unsigned NBIT_DATA     = NBIT_DATA_LEN,
    parameter int unsigned NUM_TICKS     = NUM_TICKS_DEFAULT,
    parameter int unsigned LEN_DATA      = $clog2(NBIT_DATA),
    parameter int unsigned LEN_NUM_TICKS = $clog2(NUM_TICKS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx_bit,
    output logic [NBIT_DATA-1:0] data_out,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    localparam logic [LEN_NUM_TICKS-1:0] HALF_LAST = LEN_NUM_TICKS'(NUM_TICKS / 2 - 1);
    localparam logic [LEN_NUM_TICKS-1:0] TICK_LAST = LEN_NUM_TICKS'(NUM_TICKS - 1);
    localparam logic [LEN_NUM_TICKS-1:0] TICK_ONE  = LEN_NUM_TICKS'(1);
    localparam logic [LEN_DATA-1:0]      BIT_LAST  = LEN_DATA'(NBIT_DATA - 1);
    localparam logic [LEN_DATA-1:0]      BIT_ONE   = LEN_DATA'(1);

    rx_state_e              state;
    logic [LEN_NUM_TICKS-1:0] tick_counter;
    logic [LEN_DATA-1:0]      num_bits;
    logic [NBIT_DATA-1:0]     shift_reg;
    logic                     rx_sync;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx_bit),
        .q     (rx_sync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            tick_counter <= '0;
            num_bits     <= '0;
            shift_reg    <= '0;
            data_out     <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            // Pulse is cleared every clk so it lasts exactly one cycle.
            rx_done_tick <= 1'b0;
            if (tick) begin
                case (state)
                    StIdle: begin
                        if (!rx_sync) begin
                            state        <= StStart;
                            tick_counter <= '0;
                        end
                    end
                    StStart: begin
                        if (tick_counter == HALF_LAST) begin
                            tick_counter <= '0;
                            if (!rx_sync) begin
                                state    <= StData;
                                num_bits <= '0;
                            end else begin
                                // Start bit vanished before its middle: treat as a glitch.
                                state <= StIdle;
                            end
                        end else begin
                            tick_counter <= tick_counter + TICK_ONE;
                        end
                    end
                    StData: begin
                        if (tick_counter == TICK_LAST) begin
                            tick_counter <= '0;
                            shift_reg    <= {rx_sync, shift_reg[NBIT_DATA-1:1]};
                            if (num_bits == BIT_LAST) begin
                                state <= StStop;
                            end else begin
                                num_bits <= num_bits + BIT_ONE;
                            end
                        end else begin
                            tick_counter <= tick_counter + TICK_ONE;
                        end
                    end
                    StStop: begin
                        if (tick_counter == TICK_LAST) begin
                            tick_counter <= '0;
                            data_out     <= shift_reg;
                            rx_done_tick <= 1'b1;
                            frame_err    <= ~rx_sync;
                            // Leaving at mid-stop lets a back-to-back start edge be caught.
                            state        <= rx_sync ? StIdle : StBreak;
                        end else begin
                            tick_counter <= tick_counter + TICK_ONE;
                        end
                    end
                    StBreak: begin
                        // Wait for the line to return high so a held-low line yields one frame.
                        if (rx_sync) begin
                            state <= StIdle;
                        end
                    end
                    default: begin
                        state        <= StIdle;
                        tick_counter <= '0;
                        num_bits     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receptor.sv
module tb_uart_receptor;

    localparam int NB = 8;
    localparam int NT = 16;

    logic          clk;
    logic          reset;
    logic          tick;
    logic          rx_bit;
    logic [NB-1:0] data_out;
    logic          rx_done_tick;
    logic          frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int pushed      = 0;
    int pulses      = 0;
    int tick_div    = 4;
    int div_cnt     = 0;
    logic prev_done = 1'b0;

    // Expected responses: {frame_err, data}
    logic [NB:0] exp_q[$];

    uart_receptor #(
        .NBIT_DATA (NB),
        .NUM_TICKS (NT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .rx_bit       (rx_bit),
        .data_out     (data_out),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial tick = 1'b0;
    always @(negedge clk) begin
        if (div_cnt + 1 >= tick_div) begin
            tick    = 1'b1;
            div_cnt = 0;
        end else begin
            tick    = 1'b0;
            div_cnt = div_cnt + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: pops and compares on every completed frame.
    always @(negedge clk) begin
        logic [NB:0] e;
        if (reset && rx_done_tick) begin
            pulses  = pulses + 1;
            vectors = vectors + 1;
            if (prev_done) begin
                miscompares = miscompares + 1;
                $display("FAIL done_width: rx_done_tick high two clks in a row");
            end
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL spurious_done: got data=%02h err=%0b, expected no frame",
                         data_out, frame_err);
            end else begin
                e = exp_q.pop_front();
                if ({frame_err, data_out} !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL frame: got data=%02h err=%0b, expected data=%02h err=%0b",
                             data_out, frame_err, e[NB-1:0], e[NB]);
                end
            end
        end
        prev_done = rx_done_tick;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        #1;
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        vectors = vectors + 1;
        if (data_out !== '0 || frame_err !== 1'b0 || rx_done_tick !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got data=%02h err=%0b done=%0b, expected all 0",
                     name, data_out, frame_err, rx_done_tick);
        end
    endtask

    // Behavioural transmitter: each bit lasts NT ticks; the stop bit lasts stop_ticks.
    task automatic send_frame(input logic [NB-1:0] d, input logic stop_ok, input int stop_ticks);
        exp_q.push_back({~stop_ok, d});
        pushed = pushed + 1;
        rx_bit = 1'b0;
        wait_ticks(NT);
        for (int i = 0; i < NB; i++) begin
            rx_bit = d[i];
            wait_ticks(NT);
        end
        rx_bit = stop_ok;
        wait_ticks(stop_ticks);
    endtask

    initial begin
        logic [NB-1:0] partial;
        int            budget;
        reset  = 1'b0;
        rx_bit = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        #1 reset = 1'b1;
        wait_ticks(5);

        // Single frame.
        send_frame(8'hA5, 1'b1, NT);
        wait_ticks(4);

        // Back-to-back: next start edge at tick 10 of the first stop bit.
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'hFF, 1'b1, NT);
        wait_ticks(4);

        // Short low pulse must be rejected, then a normal frame.
        rx_bit = 1'b0;
        wait_ticks(5);
        rx_bit = 1'b1;
        wait_ticks(20);
        send_frame(8'h3C, 1'b1, NT);
        wait_ticks(4);

        // Stop bit low and line held low: one error frame only.
        send_frame(8'h3C, 1'b0, 40);
        rx_bit = 1'b1;
        wait_ticks(20);
        send_frame(8'h96, 1'b1, NT);
        wait_ticks(4);

        // Reset in the middle of a frame after the 4th data bit of 0x5A.
        partial = 8'h5A;
        rx_bit  = 1'b0;
        wait_ticks(NT);
        for (int i = 0; i < 4; i++) begin
            rx_bit = partial[i];
            wait_ticks(NT);
        end
        @(negedge clk);
        reset  = 1'b0;
        rx_bit = 1'b1;
        check_zero("reset_mid_frame_0");
        check_zero("reset_mid_frame_1");
        #1 reset = 1'b1;
        check_zero("after_reset_release");
        wait_ticks(10);
        send_frame(8'h81, 1'b1, NT);
        wait_ticks(4);

        // Loopback sweep with tick on every clk.
        tick_div = 1;
        for (int v = 0; v < 256; v++) begin
            send_frame(8'(v), 1'b1, NT);
        end
        wait_ticks(8);

        // Randomized frames, tick rates, stop lengths and idle gaps.
        for (int k = 0; k < 24; k++) begin
            logic [NB-1:0] d;
            logic          ok;
            tick_div = int'($urandom_range(2, 6));
            d        = NB'($urandom);
            ok       = ($urandom_range(0, 5) != 0);
            if (ok) begin
                send_frame(d, 1'b1, int'($urandom_range(11, 16)));
                wait_ticks(int'($urandom_range(0, 6)));
            end else begin
                send_frame(d, 1'b0, int'($urandom_range(NT, 3 * NT)));
                rx_bit = 1'b1;
                wait_ticks(int'($urandom_range(3, 8)));
            end
        end
        rx_bit = 1'b1;

        budget = 0;
        while (exp_q.size() != 0 && budget < 5000) begin
            @(negedge clk);
            budget = budget + 1;
        end
        wait_ticks(2 * NT);
        vectors = vectors + 1;
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d frames never completed, expected 0", exp_q.size());
        end
        vectors = vectors + 1;
        if (pulses != pushed) begin
            miscompares = miscompares + 1;
            $display("FAIL pulse_count: got %0d pulses, expected %0d", pulses, pushed);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
